// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed seven-segment scanner: latches BCD digits, swaps them in
// tear-free at frame boundaries, scans with an anti-ghost gap and blanks leading zeros.
module bcd_display_scanner #(
  parameter int REFRESH_DIV    = 50000,
  parameter int GHOST_CYCLES   = 16,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [2:0] dig_en,
  output logic       pending
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    SLOT_ONES,
    SLOT_TENS,
    SLOT_HUNDREDS
  } slot_t;

  logic [CW-1:0] count;
  logic          tick;
  logic          frame_boundary;
  slot_t         slot, slot_next;

  logic [3:0] shadow_ones, shadow_tens, shadow_hundreds;
  logic [3:0] disp_ones, disp_tens, disp_hundreds;

  logic [3:0] cur_digit;
  logic [2:0] slot_onehot;
  logic       digit_blanked;
  logic       digit_on;
  logic [6:0] seg_next, seg_q;
  logic [2:0] dig_next, dig_q;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // non-BCD codes show a dash
    endcase
    return s;
  endfunction

  assign tick           = (count == CW'(REFRESH_DIV - 1));
  assign frame_boundary = tick && (slot == SLOT_HUNDREDS);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset is asynchronous so outputs go inactive without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot <= SLOT_ONES;
    end else begin
      slot <= slot_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    slot_next = slot;
    if (tick) begin
      case (slot)
        SLOT_ONES:     slot_next = SLOT_TENS;
        SLOT_TENS:     slot_next = SLOT_HUNDREDS;
        SLOT_HUNDREDS: slot_next = SLOT_ONES;
        default:       slot_next = SLOT_ONES;
      endcase
    end
  end

  // A load on the boundary cycle still lets the older shadow through; the new
  // capture keeps pending set so it goes out one frame later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_ones     <= '0;
      shadow_tens     <= '0;
      shadow_hundreds <= '0;
      disp_ones       <= '0;
      disp_tens       <= '0;
      disp_hundreds   <= '0;
      pending         <= 1'b0;
    end else begin
      if (frame_boundary && pending) begin
        disp_ones     <= shadow_ones;
        disp_tens     <= shadow_tens;
        disp_hundreds <= shadow_hundreds;
        pending       <= 1'b0;
      end
      if (load) begin
        shadow_ones     <= ones;
        shadow_tens     <= tens;
        shadow_hundreds <= hundreds;
        pending         <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit     = disp_ones;
    slot_onehot   = 3'b001;
    digit_blanked = 1'b0;
    case (slot)
      SLOT_TENS: begin
        cur_digit     = disp_tens;
        slot_onehot   = 3'b010;
        digit_blanked = BLANK_LEADING && (disp_hundreds == 4'd0) && (disp_tens == 4'd0);
      end
      SLOT_HUNDREDS: begin
        cur_digit     = disp_hundreds;
        slot_onehot   = 3'b100;
        digit_blanked = BLANK_LEADING && (disp_hundreds == 4'd0);
      end
      default: begin
        cur_digit     = disp_ones;
        slot_onehot   = 3'b001;
        digit_blanked = 1'b0;
      end
    endcase
    digit_on = (count >= CW'(GHOST_CYCLES)) && !blank && !digit_blanked;
    dig_next = digit_on ? slot_onehot : 3'b000;
    seg_next = digit_on ? decode(cur_digit) : 7'h00;
  end

  // Output registers hold active-high values; polarity is applied afterwards so
  // the reset value is always the inactive level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '0;
      dig_q <= '0;
    end else begin
      seg_q <= seg_next;
      dig_q <= dig_next;
    end
  end

  assign seg    = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dig_en = dig_q ^ {3{DIG_ACTIVE_LOW}};

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: a cycle model pushes expected outputs
// at each clock edge; they are popped and compared on the following falling edge.
module tb_bcd_display_scanner;

  localparam int RD = 4;
  localparam int GC = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] ones = '0, tens = '0, hundreds = '0;
  logic [6:0] seg;
  logic [2:0] dig_en;
  logic       pending;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] dig;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .REFRESH_DIV   (RD),
    .GHOST_CYCLES  (GC),
    .BLANK_LEADING (1'b1),
    .SEG_ACTIVE_LOW(1'b0),
    .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .ones    (ones),
    .tens    (tens),
    .hundreds(hundreds),
    .blank   (blank),
    .seg     (seg),
    .dig_en  (dig_en),
    .pending (pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Reference model: index 0 = ones, 1 = tens, 2 = hundreds.
  int         m_count, m_slot;
  logic [3:0] m_sh   [3];
  logic [3:0] m_disp [3];
  logic       m_pend;
  logic       m_bnd;

  assign m_bnd = (m_count == RD - 1) && (m_slot == 2);

  function automatic exp_t model_out(input int cnt, input int sl, input logic [3:0] h,
                                     input logic [3:0] t, input logic [3:0] o,
                                     input logic blk, input logic next_pend);
    exp_t r;
    logic [3:0] d;
    logic hide;
    d    = (sl == 0) ? o : (sl == 1) ? t : h;
    hide = (sl == 2 && h == 0) || (sl == 1 && h == 0 && t == 0);
    r.pend = next_pend;
    if (cnt >= GC && !blk && !hide) begin
      r.dig = 3'(1 << sl);
      r.seg = seg_of(d);
    end else begin
      r.dig = 3'b000;
      r.seg = 7'h00;
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_count <= 0;
      m_slot  <= 0;
      m_sh    <= '{4'd0, 4'd0, 4'd0};
      m_disp  <= '{4'd0, 4'd0, 4'd0};
      m_pend  <= 1'b0;
      sb.delete();
    end else begin
      sb.push_back(model_out(m_count, m_slot, m_disp[2], m_disp[1], m_disp[0], blank,
                             load ? 1'b1 : (m_bnd && m_pend) ? 1'b0 : m_pend));
      if (m_count == RD - 1) begin
        m_count <= 0;
        m_slot  <= (m_slot == 2) ? 0 : m_slot + 1;
      end else begin
        m_count <= m_count + 1;
      end
      if (m_bnd && m_pend) m_disp <= m_sh;
      if (load) begin
        m_sh   <= '{ones, tens, hundreds};
        m_pend <= 1'b1;
      end else if (m_bnd && m_pend) begin
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      check("seg", {25'd0, seg}, {25'd0, e.seg});
      check("dig_en", {29'd0, dig_en}, {29'd0, e.dig});
      check("pending", {31'd0, pending}, {31'd0, e.pend});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    hundreds = h;
    tens     = t;
    ones     = o;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pend_after_load", {31'd0, pending}, 32'd1);
  endtask

  task automatic wait_boundary();
    int i;
    i = 0;
    while (!m_bnd && i < 3 * RD + 2) begin
      @(negedge clk);
      i++;
    end
    check("boundary_found", {31'd0, m_bnd}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg", {25'd0, seg}, 32'd0);
    check("rst_dig", {29'd0, dig_en}, 32'd0);
    check("rst_pend", {31'd0, pending}, 32'd0);
    reset_n = 1'b1;
    cycles(24);

    do_load(4'd1, 4'd2, 4'd3);
    cycles(30);
    do_load(4'd0, 4'd0, 4'd7);
    cycles(30);
    do_load(4'd0, 4'd5, 4'd0);
    cycles(30);

    // load landing exactly on the frame boundary
    do_load(4'd2, 4'd4, 4'd6);
    wait_boundary();
    hundreds = 4'd9;
    tens     = 4'd8;
    ones     = 4'd7;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pend_on_boundary", {31'd0, pending}, 32'd1);
    cycles(30);

    do_load(4'd0, 4'd0, 4'hC);
    cycles(15);
    blank = 1'b1;
    cycles(2);
    check("blank_dig", {29'd0, dig_en}, 32'd0);
    cycles(12);
    blank = 1'b0;
    cycles(12);

    repeat (6) begin
      do_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycles($urandom_range(3, 15));
    end
    cycles(24);

    // reset mid-slot with a capture still pending
    do_load(4'd3, 4'd3, 4'd3);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_seg", {25'd0, seg}, 32'd0);
    check("midrst_dig", {29'd0, dig_en}, 32'd0);
    check("midrst_pend", {31'd0, pending}, 32'd0);
    cycles(2);
    reset_n = 1'b1;
    cycles(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
